// File: rtl/pulse_timer_pkg.sv
// Shared types for the multi-channel pulse timer.
// Channel state enum, mode encodings, cfg index width helper.
package pulse_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } st_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_timer_ch.sv
// One timer channel: IDLE/RUN FSM, counter, active+shadow cfg.
// Ports: clk, rst, start, stop, wr/wr_per/wr_one in; sig, busy, pend out.
module pulse_timer_ch
  import pulse_timer_pkg::*;
#(
  parameter int CBITS      = 10,
  parameter int DEF_PERIOD = 750
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             wr,
  input  logic [CBITS-1:0] wr_per,
  input  logic             wr_one,
  output logic             sig,
  output logic             busy,
  output logic             pend
);

  localparam logic [CBITS-1:0] DEF = DEF_PERIOD[CBITS-1:0];
  localparam logic [CBITS-1:0] ONE = 1;

  st_t              st, st_n;
  logic [CBITS-1:0] cnt, cnt_n;
  logic [CBITS-1:0] per, per_n;
  logic [CBITS-1:0] sh_per, sh_per_n;
  logic             one, one_n;
  logic             sh_one, sh_one_n;
  logic             pend_n;
  logic             sig_n;
  logic             wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= '0;
      per    <= DEF;
      sh_per <= DEF;
      one    <= MODE_PERIODIC;
      sh_one <= MODE_PERIODIC;
      pend   <= 1'b0;
      sig    <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      per    <= per_n;
      sh_per <= sh_per_n;
      one    <= one_n;
      sh_one <= sh_one_n;
      pend   <= pend_n;
      sig    <= sig_n;
    end
  end

  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    per_n    = per;
    sh_per_n = sh_per;
    one_n    = one;
    sh_one_n = sh_one;
    pend_n   = pend;
    sig_n    = 1'b0;
    wrap     = (st == RUN) && (cnt >= per);

    if (wr) begin
      sh_per_n = wr_per;
      sh_one_n = wr_one;
      pend_n   = 1'b1;
    end

    // An idle channel takes new cfg straight away, so a
    // same-cycle start counts against the new period.
    if (st == IDLE) begin
      if (wr) begin
        per_n  = wr_per;
        one_n  = wr_one;
        pend_n = 1'b0;
      end else if (pend) begin
        per_n  = sh_per;
        one_n  = sh_one;
        pend_n = 1'b0;
      end
    end

    unique case (1'b1)
      stop: begin
        st_n  = IDLE;
        cnt_n = '0;
      end
      start && !stop: begin
        st_n  = RUN;
        cnt_n = '0;
      end
      wrap && !start && !stop: begin
        cnt_n = '0;
        sig_n = 1'b1;
        if (one == MODE_ONESHOT) st_n = IDLE;
        if (pend) begin
          per_n  = sh_per;
          one_n  = sh_one;
          pend_n = 1'b0;
        end
      end
      default: begin
        if (st == RUN) cnt_n = cnt + ONE;
      end
    endcase
  end

  assign busy = (st == RUN);

endmodule

// File: rtl/pulse_timer_mc.sv
// NCH-channel pulse timer with a valid/ready cfg write port.
// Ports: clk, rst, start, stop, cfg_*; sig, busy, cfg_ready.
module pulse_timer_mc
  import pulse_timer_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CBITS      = 10,
  parameter int DEF_PERIOD = 750
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        start,
  input  logic [NCH-1:0]        stop,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [chw(NCH)-1:0]   cfg_ch,
  input  logic [CBITS-1:0]      cfg_period,
  input  logic                  cfg_oneshot,
  output logic [NCH-1:0]        sig,
  output logic [NCH-1:0]        busy
);

  localparam int CW = chw(NCH);

  logic [NCH-1:0] pend;
  logic [NCH-1:0] wr;

  // Out-of-range cfg_ch matches no channel: ready, then dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (pend[i] && cfg_ch == CW'(i)) cfg_ready = 1'b0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = cfg_valid && cfg_ready
                && (cfg_ch == CW'(i));

    pulse_timer_ch #(
      .CBITS      (CBITS),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .start  (start[i]),
      .stop   (stop[i]),
      .wr     (wr[i]),
      .wr_per (cfg_period),
      .wr_one (cfg_oneshot),
      .sig    (sig[i]),
      .busy   (busy[i]),
      .pend   (pend[i])
    );
  end

endmodule

// File: tb/tb_pulse_timer_mc.sv
// Directed self-checking bench for pulse_timer_mc.
// Checks sampled 1 time unit after each rising edge.
module tb_pulse_timer_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start;
  logic [3:0] stop;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [9:0] cfg_period;
  logic       cfg_oneshot;
  logic [3:0] sig;
  logic [3:0] busy;

  int n_cmp = 0;
  int n_err = 0;
  int bad;

  always #5 clk = ~clk;

  pulse_timer_mc dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_oneshot (cfg_oneshot),
    .sig         (sig),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] ch,
                     input logic [9:0] p,
                     input logic os);
    cfg_valid   = 1'b1;
    cfg_ch      = ch;
    cfg_period  = p;
    cfg_oneshot = os;
    tick();
    cfg_valid   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = '0;
    stop = '0;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_period = '0;
    cfg_oneshot = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_sig", 32'(sig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(cfg_ready), 1);

    // P=3 periodic on ch0
    cfg(2'd0, 10'd3, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("p3_busy", 32'(busy[0]), 1);
    chk("p3_sig0", 32'(sig[0]), 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("p3_sig_e%0d", k),
          32'(sig[0]), 32'((k % 4) == 0));
    end
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    chk("p3_stop_busy", 32'(busy[0]), 0);
    chk("p3_stop_sig", 32'(sig[0]), 0);

    // P=2 one-shot on ch1
    cfg(2'd1, 10'd2, 1'b1);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    chk("os_busy0", 32'(busy[1]), 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("os_sig_e%0d", k),
          32'(sig[1]), 32'(k == 3));
      chk($sformatf("os_busy_e%0d", k),
          32'(busy[1]), 32'(k < 3));
    end

    // ch0 P=5, retarget to P=1 at count 2
    cfg(2'd0, 10'd5, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_period = 10'd1;
    cfg_oneshot = 1'b0;
    chk("upd_rdy1", 32'(cfg_ready), 1);
    tick();
    chk("upd_e3", 32'(sig[0]), 0);
    cfg_period = 10'd7;
    chk("upd_rdy0", 32'(cfg_ready), 0);
    tick();
    chk("upd_rdy0b", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    for (int k = 5; k <= 12; k++) begin
      tick();
      chk($sformatf("upd_sig_e%0d", k),
          32'(sig[0]), 32'(k >= 6 && (k % 2) == 0));
      if (k == 6) chk("upd_rdy_wrap", 32'(cfg_ready), 1);
    end
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;

    // ch2 start+stop collision and restart
    cfg(2'd2, 10'd3, 1'b0);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    tick();
    tick();
    start[2] = 1'b1;
    stop[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    stop[2] = 1'b0;
    chk("coll_busy", 32'(busy[2]), 0);
    chk("coll_sig", 32'(sig[2]), 0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (sig[2] !== 1'b0 || busy[2] !== 1'b0) bad++;
    end
    chk("coll_quiet", 32'(bad), 0);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    tick();
    tick();
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    chk("rs_sig0", 32'(sig[2]), 0);
    chk("rs_busy", 32'(busy[2]), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("rs_sig_e%0d", k),
          32'(sig[2]), 32'(k == 4));
    end
    stop[2] = 1'b1;
    tick();
    stop[2] = 1'b0;

    // reset mid-count with pending cfg
    cfg(2'd0, 10'd4, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    cfg(2'd0, 10'd9, 1'b0);
    chk("pre_rst_rdy", 32'(cfg_ready), 0);
    rst = 1'b1;
    start[1] = 1'b1;
    tick();
    rst = 1'b0;
    start[1] = 1'b0;
    chk("mid_rst_sig", 32'(sig), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rdy", 32'(cfg_ready), 1);

    // default period 750 -> pulse every 751 clocks
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    bad = 0;
    for (int k = 1; k <= 1502; k++) begin
      tick();
      if (k == 751) chk("def_p1", 32'(sig[0]), 1);
      else if (k == 1502) chk("def_p2", 32'(sig[0]), 1);
      else if (sig[0] !== 1'b0) bad++;
    end
    chk("def_gap", 32'(bad), 0);
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;

    // P=0 -> sig high every cycle while running
    cfg(2'd3, 10'd0, 1'b0);
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    chk("p0_busy", 32'(busy[3]), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("p0_sig_e%0d", k), 32'(sig[3]), 1);
    end
    stop[3] = 1'b1;
    tick();
    stop[3] = 1'b0;
    chk("p0_stop_sig", 32'(sig[3]), 0);
    chk("p0_stop_busy", 32'(busy[3]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
